// File: rtl/v8502_bus_master.sv
// Bus initiator for an 8502-style CPU bus: derives non-overlapping phi1/phi2 from
// the system clock and runs single host-requested read/write cycles with RDY stretching.
module v8502_bus_master #(
  parameter int PHASE_CLKS = 6,
  parameter int GAP_CLKS   = 2,
  parameter int HOLD_CLKS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        phi1,
  output logic        phi2,
  output logic [15:0] address,
  output logic        r_w,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  input  logic        rdy
);

  localparam int MAX_CLKS = (PHASE_CLKS > GAP_CLKS) ? PHASE_CLKS : GAP_CLKS;
  localparam int CW       = $clog2(MAX_CLKS) + 1;
  localparam int HOLD_IDX = (HOLD_CLKS > 0) ? HOLD_CLKS - 1 : 0;

  typedef enum logic [1:0] {
    ST_PHI1,
    ST_GAP1,
    ST_PHI2,
    ST_GAP2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phi1_q, phi1_d;
  logic          phi2_q, phi2_d;
  logic [15:0]   address_q, address_d;
  logic          r_w_q, r_w_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          retry_q, retry_d;

  logic phase_end;
  logic start_edge;
  logic phi1_fall;
  logic phi2_rise;
  logic phi2_fall;
  logic hold_end;

  // Decode the clock edge at which the current phase ends.
  always_comb begin
    if (state_q == ST_PHI1 || state_q == ST_PHI2) begin
      phase_end = (cnt_q == CW'(PHASE_CLKS - 1));
    end else begin
      phase_end = (cnt_q == CW'(GAP_CLKS - 1));
    end
    start_edge = (state_q == ST_GAP2) && phase_end;
    phi1_fall  = (state_q == ST_PHI1) && phase_end;
    phi2_rise  = (state_q == ST_GAP1) && phase_end;
    phi2_fall  = (state_q == ST_PHI2) && phase_end;
    if (HOLD_CLKS == 0) begin
      hold_end = phi2_fall;
    end else begin
      hold_end = (state_q == ST_GAP2) && (cnt_q == CW'(HOLD_IDX));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (phase_end) begin
      cnt_d = '0;
      case (state_q)
        ST_PHI1: state_d = ST_GAP1;
        ST_GAP1: state_d = ST_PHI2;
        ST_PHI2: state_d = ST_GAP2;
        ST_GAP2: state_d = ST_PHI1;
        default: state_d = ST_GAP2;
      endcase
    end
    phi1_d = (state_d == ST_PHI1);
    phi2_d = (state_d == ST_PHI2);
  end

  // Bus-cycle control: acceptance, RDY retry, write drive window and completion.
  always_comb begin
    address_d  = address_q;
    r_w_d      = r_w_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    retry_d    = retry_q;

    if (start_edge && !busy_q) begin
      if (req) begin
        busy_d    = 1'b1;
        address_d = req_addr;
        r_w_d     = ~req_we;
        wdata_d   = req_wdata;
      end else begin
        r_w_d = 1'b1;
      end
    end

    if (phi1_fall) begin
      retry_d = r_w_q & ~rdy;
    end

    if (phi2_rise && !r_w_q) begin
      data_oe_d  = 1'b1;
      data_out_d = wdata_q;
    end

    if (hold_end) begin
      data_oe_d = 1'b0;
    end

    // A retried cycle keeps busy set so the same request is replayed next cycle.
    if (phi2_fall && busy_q && !retry_q) begin
      ack_d  = 1'b1;
      busy_d = 1'b0;
      if (r_w_q) begin
        rdata_d = data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GAP2;
      cnt_q      <= CW'(GAP_CLKS - 1);
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
      address_q  <= 16'h0000;
      r_w_q      <= 1'b1;
      wdata_q    <= 8'h00;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      retry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phi1_q     <= phi1_d;
      phi2_q     <= phi2_d;
      address_q  <= address_d;
      r_w_q      <= r_w_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      retry_q    <= retry_d;
    end
  end

  assign phi1     = phi1_q;
  assign phi2     = phi2_q;
  assign address  = address_q;
  assign r_w      = r_w_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_v8502_bus_master.sv
// Scoreboard bench for v8502_bus_master: a host driver issues requests and a bus
// agent with its own memory answers reads; a monitor checks acks and write cycles.
module tb_v8502_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        phi1;
  logic        phi2;
  logic [15:0] address;
  logic        r_w;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in = 8'h00;
  logic        rdy = 1'b1;

  v8502_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .phi1      (phi1),
    .phi2      (phi2),
    .address   (address),
    .r_w       (r_w),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in),
    .rdy       (rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  rdata;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t ack_sb[$];
  wr_t  wr_sb[$];

  logic [7:0] host_mem [logic [15:0]];
  logic [7:0] bus_mem  [logic [15:0]];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_ack_cyc = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [7:0]  last_rdata = 8'h00;
  logic        exp_oe = 1'b0;

  logic        cur_we;
  logic [15:0] cur_addr;
  int          stall_left;
  int          cycles;
  bit          scramble_en;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] host_rd(input logic [15:0] a);
    if (host_mem.exists(a)) return host_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [15:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return dflt(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus agent and monitor: answers reads from bus_mem, checks acks and the write window.
  initial begin : monitor
    logic phi2_prev;
    bit   oe_check_next;
    exp_t e;
    wr_t  w;
    phi2_prev = 1'b0;
    oe_check_next = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        oe_check_next = 0;
      end else begin
        data_in = phi2 ? bus_rd(address) : 8'($urandom);
        checkOutput("phi_overlap", {31'd0, phi1 & phi2}, 32'd0);
        checkOutput("oe_while_read", {31'd0, data_oe & r_w}, 32'd0);
        if (ack) begin
          if (ack_sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: got ack=1 at addr %0h expected no ack", address);
          end else begin
            e = ack_sb.pop_front();
            checkOutput("ack_rdata", {24'd0, rdata}, {24'd0, e.rdata});
            checkOutput("ack_addr", {16'd0, address}, {16'd0, e.addr});
            checkOutput("ack_busy", {31'd0, busy}, 32'd0);
          end
        end
        if (phi2 && !phi2_prev) begin
          checkOutput("oe_at_phi2_rise", {31'd0, data_oe}, {31'd0, exp_oe});
        end
        if (!phi2 && phi2_prev) begin
          checkOutput("oe_hold", {31'd0, data_oe}, {31'd0, exp_oe});
          if (data_oe) begin
            if (wr_sb.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_write: got write %0h<-%0h expected none", address, data_out);
            end else begin
              w = wr_sb.pop_front();
              checkOutput("bus_wr_addr", {16'd0, address}, {16'd0, w.addr});
              checkOutput("bus_wr_data", {24'd0, data_out}, {24'd0, w.data});
            end
            bus_mem[address] = data_out;
          end
          oe_check_next = exp_oe;
        end else if (oe_check_next) begin
          checkOutput("oe_release", {31'd0, data_oe}, 32'd0);
          oe_check_next = 0;
        end
      end
      phi2_prev = phi2;
    end
  end

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = phi1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (phi1 && !prev) begin
        ok = 1;
        break;
      end
      prev = phi1;
    end
  endtask

  // Called on the first clk of each bus cycle belonging to the current request.
  task automatic handle_cycle();
    cycles++;
    exp_oe = cur_we;
    checkOutput("cyc_addr", {16'd0, address}, {16'd0, cur_addr});
    checkOutput("cyc_r_w", {31'd0, r_w}, {31'd0, ~cur_we});
    checkOutput("cyc_busy", {31'd0, busy}, 32'd1);
    if (stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else begin
      rdy = 1'b1;
    end
    if (scramble_en) begin
      req_addr  = 16'($urandom);
      req_we    = 1'($urandom);
      req_wdata = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                               input int stalls, input bit scramble, input bit chk_gap);
    exp_t e;
    wr_t  w;
    bit   ok;
    bit   done;
    logic prev;
    int   exp_cycles;
    req = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    e.addr = addr;
    e.rdata = we ? last_rdata : host_rd(addr);
    ack_sb.push_back(e);
    if (we) begin
      w.addr = addr;
      w.data = wd;
      wr_sb.push_back(w);
    end
    cur_we = we;
    cur_addr = addr;
    stall_left = stalls;
    cycles = 0;
    scramble_en = scramble;
    exp_cycles = we ? 1 : stalls + 1;
    wait_rise(ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no phi1 rise expected one within 40 clks");
      return;
    end
    handle_cycle();
    prev = 1'b1;
    done = 0;
    for (int i = 0; i < 16 * (stalls + 2); i++) begin
      @(negedge clk);
      if (ack) begin
        done = 1;
        break;
      end
      if (phi1 && !prev) handle_cycle();
      prev = phi1;
    end
    checkOutput("ack_seen", {31'd0, done}, 32'd1);
    checkOutput("bus_cycles", cycles, exp_cycles);
    if (chk_gap) checkOutput("ack_spacing", cyc - last_ack_cyc, 16 * exp_cycles);
    last_ack_cyc = cyc;
    if (we) host_mem[addr] = wd;
    else last_rdata = e.rdata;
    last_addr = addr;
    rdy = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    bit ok;
    req = 1'b0;
    for (int k = 0; k < n; k++) begin
      wait_rise(ok);
      checkOutput("idle_rise", {31'd0, ok}, 32'd1);
      exp_oe = 1'b0;
      checkOutput("dummy_addr", {16'd0, address}, {16'd0, last_addr});
      checkOutput("dummy_r_w", {31'd0, r_w}, 32'd1);
      rdy = 1'($urandom);
    end
    rdy = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_phi1"}, {31'd0, phi1}, 32'd0);
    checkOutput({tag, "_phi2"}, {31'd0, phi2}, 32'd0);
    checkOutput({tag, "_address"}, {16'd0, address}, 32'd0);
    checkOutput({tag, "_r_w"}, {31'd0, r_w}, 32'd1);
    checkOutput({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    checkOutput({tag, "_data_oe"}, {31'd0, data_oe}, 32'd0);
    checkOutput({tag, "_ack"}, {31'd0, ack}, 32'd0);
    checkOutput({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : driver
    int          p1_rise;
    int          p1_rise2;
    int          p2_rise;
    logic        pp1;
    logic        pp2;
    logic [15:0] pool [0:4];
    bit          b2b;
    bit          ok;
    logic        we;
    logic [15:0] addr;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    p1_rise = -1;
    p1_rise2 = -1;
    p2_rise = -1;
    pp1 = 1'b0;
    pp2 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (phi1 && !pp1) begin
        if (p1_rise < 0) p1_rise = n;
        else if (p1_rise2 < 0) p1_rise2 = n;
      end
      if (phi2 && !pp2 && p2_rise < 0) p2_rise = n;
      pp1 = phi1;
      pp2 = phi2;
    end
    checkOutput("first_phi1_rise", p1_rise, 1);
    checkOutput("first_phi2_rise", p2_rise, 9);
    checkOutput("cycle_period", p1_rise2 - p1_rise, 16);

    host_mem[16'hD500] = 8'hA5;
    bus_mem[16'hD500]  = 8'hA5;
    applyStimulus(1'b1, 16'h0001, 8'h37, 0, 0, 0);
    applyStimulus(1'b0, 16'hD500, 8'h00, 0, 0, 1);
    applyStimulus(1'b0, 16'hFF00, 8'h00, 2, 0, 1);
    applyStimulus(1'b1, 16'hFF00, 8'h9C, 2, 0, 1);
    host_mem[16'h0001] = 8'h55;
    bus_mem[16'h0001]  = 8'h55;
    applyStimulus(1'b1, 16'h0000, 8'h2F, 0, 1, 1);
    applyStimulus(1'b0, 16'h0001, 8'h00, 0, 0, 1);
    idle_cycles(3);

    pool[0] = 16'h0000;
    pool[1] = 16'h0001;
    pool[2] = 16'hD500;
    pool[3] = 16'hFF00;
    b2b = 0;
    for (int t = 0; t < 30; t++) begin
      pool[4] = 16'($urandom);
      we = 1'($urandom);
      addr = pool[$urandom_range(0, 4)];
      applyStimulus(we, addr, 8'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), b2b);
      if ($urandom_range(0, 2) == 0) begin
        idle_cycles($urandom_range(1, 2));
        b2b = 0;
      end else begin
        b2b = 1;
      end
    end
    idle_cycles(1);

    // Abort a write in the middle of PHI2 with an asynchronous reset.
    req = 1'b1;
    req_we = 1'b1;
    req_addr = 16'h1234;
    req_wdata = 8'hC3;
    wait_rise(ok);
    checkOutput("abort_accept", {31'd0, ok}, 32'd1);
    exp_oe = 1'b1;
    for (int i = 0; i < 20 && !phi2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("abort_oe_before", {31'd0, data_oe}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("abort");
    req = 1'b0;
    exp_oe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_addr = 16'h0000;
    last_rdata = 8'h00;
    idle_cycles(2);
    repeat (4) @(negedge clk);

    checkOutput("ack_sb_empty", ack_sb.size(), 0);
    checkOutput("wr_sb_empty", wr_sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
